// File: rtl/pool_channel_scheduler_pkg.sv
`default_nettype none
// pool_channel_scheduler_pkg -- shared widths, FSM encoding and config check for the channel scheduler.
// Rev 1.0
package pool_channel_scheduler_pkg;

  localparam int ACC_WIDTH  = 16;
  localparam int MAX_LINE_W = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } sched_state_e;

  // 2x2 pooling needs non-zero even dimensions so every channel ends on an even row.
  function automatic logic dims_invalid(input logic [15:0] w, input logic [15:0] h);
    return (w == 16'd0) || w[0] || (h == 16'd0) || h[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_ch_rr_pick.sv
`default_nettype none
// pool_ch_rr_pick -- finds the lowest set mask bit above (or at, when inclusive) a given channel index.
// Rev 1.0
module pool_ch_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [IDX_W-1:0]  from_idx,
  input  logic              inclusive,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  // Scan downwards so the lowest qualifying channel is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from_idx)) || (inclusive && (i == int'(from_idx))))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool_channel_scheduler.sv
`default_nettype none
// pool_channel_scheduler -- serves whole channel feature maps one at a time to a shared 2x2 pooling core
// and tags the returned results with their channel. Rev 1.0
module pool_channel_scheduler
  import pool_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = ACC_WIDTH,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_async_n_i,
  input  logic                          start_i,
  input  logic [15:0]                   fm_w_i,
  input  logic [15:0]                   fm_h_i,
  input  logic [NUM_CH-1:0]             ch_mask_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  input  logic [NUM_CH-1:0]             in_valid_i,
  output logic [NUM_CH-1:0]             in_ready_o,
  input  logic [NUM_CH-1:0][WIDTH-1:0]  in_data_i,
  output logic                          pool_valid_o,
  input  logic                          pool_ready_i,
  output logic [WIDTH-1:0]              pool_data_o,
  output logic [31:0]                   pool_fm_w_o,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  input  logic [WIDTH-1:0]              res_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [WIDTH-1:0]              out_data_o,
  output logic [CH_W-1:0]               out_ch_o,
  output logic                          out_last_o
);

  sched_state_e      state;
  sched_state_e      state_next;

  logic [15:0]       fm_w;
  logic [NUM_CH-1:0] mask;
  logic [31:0]       pix_total;
  logic [31:0]       in_cnt;
  logic [31:0]       out_cnt;
  logic [CH_W-1:0]   cur_ch;

  logic [31:0]       res_total;
  logic              in_accept;
  logic              out_accept;
  logic              out_complete;
  logic              start_bad;
  logic              latch_cfg;
  logic              ch_done;
  logic              err_next;
  logic              done_next;
  logic              first_found;
  logic [CH_W-1:0]   first_idx;
  logic              next_found;
  logic [CH_W-1:0]   next_idx;

  pool_ch_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_first_pick (
    .mask      (ch_mask_i),
    .from_idx  ('0),
    .inclusive (1'b1),
    .found     (first_found),
    .idx       (first_idx)
  );

  pool_ch_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_next_pick (
    .mask      (mask),
    .from_idx  (cur_ch),
    .inclusive (1'b0),
    .found     (next_found),
    .idx       (next_idx)
  );

  // W and H are both even, so W*H is a multiple of four and the shift is exact.
  assign res_total    = pix_total >> 2;
  assign start_bad    = dims_invalid(fm_w_i, fm_h_i) || !first_found;
  assign in_accept    = (state == ST_STREAM) && in_valid_i[cur_ch] && pool_ready_i;
  assign out_accept   = (state != ST_IDLE) && res_valid_i && out_ready_i;
  assign out_complete = (out_cnt == res_total) ||
                        (out_accept && (out_cnt == res_total - 32'd1));
  assign pool_fm_w_o  = {16'h0000, fm_w};

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    latch_cfg    = 1'b0;
    ch_done      = 1'b0;
    err_next     = 1'b0;
    done_next    = 1'b0;
    pool_valid_o = 1'b0;
    pool_data_o  = '0;
    in_ready_o   = '0;
    out_valid_o  = 1'b0;
    out_data_o   = '0;
    res_ready_o  = 1'b0;
    out_ch_o     = '0;
    out_last_o   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (start_bad) begin
            err_next = 1'b1;
          end else begin
            latch_cfg  = 1'b1;
            state_next = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (in_accept && (in_cnt == pix_total - 32'd1)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_complete) begin
          ch_done = 1'b1;
          if (next_found) begin
            state_next = ST_STREAM;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (state == ST_STREAM) begin
      pool_valid_o       = in_valid_i[cur_ch];
      pool_data_o        = in_data_i[cur_ch];
      in_ready_o[cur_ch] = pool_ready_i;
    end

    if (state != ST_IDLE) begin
      out_valid_o = res_valid_i;
      out_data_o  = res_data_i;
      res_ready_o = out_ready_i;
      out_ch_o    = cur_ch;
      out_last_o  = res_valid_i && (out_cnt == res_total - 32'd1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      fm_w      <= '0;
      mask      <= '0;
      pix_total <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      cur_ch    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      busy_o <= (state_next != ST_IDLE);
      done_o <= done_next;
      err_o  <= err_next;
      if (latch_cfg) begin
        fm_w      <= fm_w_i;
        mask      <= ch_mask_i;
        pix_total <= 32'(fm_w_i) * 32'(fm_h_i);
        cur_ch    <= first_idx;
        in_cnt    <= '0;
        out_cnt   <= '0;
      end else if (ch_done) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        if (next_found) begin
          cur_ch <= next_idx;
        end
      end else begin
        if (in_accept) begin
          in_cnt <= in_cnt + 32'd1;
        end
        if (out_accept) begin
          out_cnt <= out_cnt + 32'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_channel_scheduler.sv
`default_nettype none
// tb_pool_channel_scheduler -- directed checks of job sequencing, channel muxing, result tagging,
// configuration errors and reset behaviour, with a behavioural 2x2 max-pool core attached.
module tb_pool_channel_scheduler;
  import pool_channel_scheduler_pkg::*;

  localparam int NCH = 4;
  localparam int PW  = ACC_WIDTH;

  logic                     clk = 1'b0;
  logic                     rst_async_n_i;
  logic                     start_i;
  logic [15:0]              fm_w_i;
  logic [15:0]              fm_h_i;
  logic [NCH-1:0]           ch_mask_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;
  logic [NCH-1:0]           in_valid_i;
  logic [NCH-1:0]           in_ready_o;
  logic [NCH-1:0][PW-1:0]   in_data_i;
  logic                     pool_valid_o;
  logic                     pool_ready_i;
  logic [PW-1:0]            pool_data_o;
  logic [31:0]              pool_fm_w_o;
  logic                     res_valid_i;
  logic                     res_ready_o;
  logic [PW-1:0]            res_data_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [PW-1:0]            out_data_o;
  logic [1:0]               out_ch_o;
  logic                     out_last_o;

  pool_channel_scheduler dut (
    .clk_i         (clk),
    .rst_async_n_i (rst_async_n_i),
    .start_i       (start_i),
    .fm_w_i        (fm_w_i),
    .fm_h_i        (fm_h_i),
    .ch_mask_i     (ch_mask_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .pool_valid_o  (pool_valid_o),
    .pool_ready_i  (pool_ready_i),
    .pool_data_o   (pool_data_o),
    .pool_fm_w_o   (pool_fm_w_o),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .res_data_i    (res_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_ch_o      (out_ch_o),
    .out_last_o    (out_last_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int pix [NCH][16];
  int npix [NCH];
  int ptr [NCH];

  logic signed [15:0] res_q [$];
  logic signed [15:0] pbuf [16];
  logic [15:0]        obs_data [$];
  logic [1:0]         obs_ch [$];
  logic               obs_last [$];
  int                 pool_acc;
  int                 done_cnt;
  int                 stray;

  function automatic logic signed [15:0] max2(input logic signed [15:0] a, input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Drives one job: the bench plays both the channel sources and the pooling core.
  task automatic run_job(input int w, input int h, input logic [3:0] mask, input bit rnd_valid,
                         input bit tog_ready, input int glitch_cyc, input int stop_acc);
    int  core_k;
    int  r;
    int  col;
    int  extra;
    int  nch;
    bit  seen_done;
    bit  stopped;
    core_k = 0; extra = 0; seen_done = 0; stopped = 0;
    res_q.delete(); obs_data.delete(); obs_ch.delete(); obs_last.delete();
    pool_acc = 0; done_cnt = 0; stray = 0;
    for (int c = 0; c < NCH; c++) ptr[c] = 0;
    @(negedge clk);
    start_i = 1'b1; fm_w_i = 16'(w); fm_h_i = 16'(h); ch_mask_i = mask;
    @(negedge clk);
    start_i = 1'b0; fm_w_i = 16'd6; fm_h_i = 16'd6; ch_mask_i = 4'b1111;
    #1;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL busy_after_start: got %0b expected 1", busy_o);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        in_valid_i[c] = (ptr[c] < npix[c]) && (!rnd_valid || ($urandom_range(0, 3) != 0));
        in_data_i[c]  = (ptr[c] < npix[c]) ? 16'(pix[c][ptr[c]]) : 16'h0000;
      end
      res_valid_i  = (res_q.size() > 0);
      res_data_i   = (res_q.size() > 0) ? res_q[0] : 16'h0000;
      out_ready_i  = tog_ready ? cyc[0] : 1'b1;
      pool_ready_i = 1'b1;
      start_i      = (cyc == glitch_cyc);
      #1;
      if (cyc == 8) begin
        n_cmp++;
        if (pool_fm_w_o !== 32'(w)) begin
          n_bad++; $display("FAIL fm_w_latched: got %0d expected %0d", pool_fm_w_o, w);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (in_ready_o[c] && !mask[c]) stray++;
        if (in_valid_i[c] && in_ready_o[c]) ptr[c]++;
      end
      if (out_valid_o && out_ready_i) begin
        obs_data.push_back(out_data_o);
        obs_ch.push_back(out_ch_o);
        obs_last.push_back(out_last_o);
        if (res_q.size() > 0) void'(res_q.pop_front());
      end
      if (pool_valid_o && pool_ready_i) begin
        pbuf[core_k] = pool_data_o;
        r   = core_k / w;
        col = core_k % w;
        if ((r % 2 == 1) && (col % 2 == 1)) begin
          res_q.push_back(max2(max2(pbuf[(r-1)*w + col-1], pbuf[(r-1)*w + col]),
                               max2(pbuf[r*w + col-1], pbuf[r*w + col])));
        end
        core_k++;
        if (core_k == w * h) core_k = 0;
        pool_acc++;
      end
      if (done_o) begin
        done_cnt++;
        if (!seen_done) begin
          n_cmp++;
          if (busy_o !== 1'b0) begin
            n_bad++; $display("FAIL busy_at_done: got %0b expected 0", busy_o);
          end
        end
        seen_done = 1;
      end
      if ((stop_acc > 0) && (pool_acc == stop_acc)) begin
        stopped = 1;
        break;
      end
      if (seen_done) extra++;
      if (extra > 4) break;
      @(negedge clk);
    end
    start_i = 1'b0;
    if (stopped) begin
      @(posedge clk);
      return;
    end
    in_valid_i = '0; res_valid_i = 1'b0;
    nch = 0;
    for (int c = 0; c < NCH; c++) if (mask[c]) nch++;
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++; $display("FAIL done_pulses: got %0d expected 1", done_cnt);
    end
    n_cmp++;
    if (stray !== 0) begin
      n_bad++; $display("FAIL stray_ready: got %0d cycles expected 0", stray);
    end
    n_cmp++;
    if (pool_acc !== nch * w * h) begin
      n_bad++; $display("FAIL pixels_streamed: got %0d expected %0d", pool_acc, nch * w * h);
    end
  endtask

  task automatic test_reset;
    rst_async_n_i = 1'b0;
    start_i = 1'b0; fm_w_i = '0; fm_h_i = '0; ch_mask_i = '0;
    in_valid_i = '1; in_data_i = '0; pool_ready_i = 1'b1;
    res_valid_i = 1'b1; res_data_i = 16'h1234; out_ready_i = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_status: got %b expected 000", {busy_o, done_o, err_o});
    end
    n_cmp++;
    if ({pool_valid_o, in_ready_o, res_ready_o, out_valid_o, out_last_o} !== 8'h00) begin
      n_bad++; $display("FAIL reset_handshake: got %b expected 00000000",
                        {pool_valid_o, in_ready_o, res_ready_o, out_valid_o, out_last_o});
    end
    n_cmp++;
    if ({pool_fm_w_o, out_ch_o, out_data_o} !== 50'd0) begin
      n_bad++; $display("FAIL reset_data: got fm_w=%0d ch=%0d data=%0d expected 0/0/0",
                        pool_fm_w_o, out_ch_o, out_data_o);
    end
    repeat (2) @(negedge clk);
    rst_async_n_i = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy_o, out_valid_o, res_ready_o, in_ready_o} !== 7'b0) begin
      n_bad++; $display("FAIL idle_gating: got %b expected 0000000",
                        {busy_o, out_valid_o, res_ready_o, in_ready_o});
    end
    in_valid_i = '0; res_valid_i = 1'b0;
  endtask

  task automatic test_config_error;
    int cw [4] = '{5, 4, 4, 4};
    int chh [4] = '{4, 0, 4, 3};
    logic [3:0] cm [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_i = 1'b1; fm_w_i = 16'(cw[k]); fm_h_i = 16'(chh[k]); ch_mask_i = cm[k];
      @(negedge clk);
      start_i = 1'b0;
      #1;
      n_cmp++;
      if ({err_o, busy_o} !== 2'b10) begin
        n_bad++; $display("FAIL cfg_err_pulse[%0d]: got err=%0b busy=%0b expected err=1 busy=0", k, err_o, busy_o);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({err_o, busy_o} !== 2'b00) begin
        n_bad++; $display("FAIL cfg_err_clear[%0d]: got err=%0b busy=%0b expected 0/0", k, err_o, busy_o);
      end
    end
    n_cmp++;
    if (pool_fm_w_o !== 32'd0) begin
      n_bad++; $display("FAIL cfg_not_latched: got %0d expected 0", pool_fm_w_o);
    end
  endtask

  task automatic load_ch0_grid;
    pix[0] = '{1, -2, 3, 4, 5, 0, -1, -7, -8, -3, 9, 2, -4, -5, 6, 10};
    npix[0] = 16; npix[1] = 0; npix[2] = 0; npix[3] = 0;
  endtask

  task automatic test_single_channel;
    int ed [4] = '{5, 4, -3, 10};
    load_ch0_grid();
    run_job(4, 4, 4'b0001, 0, 0, -1, 0);
    n_cmp++;
    if (obs_data.size() !== 4) begin
      n_bad++; $display("FAIL single_count: got %0d expected 4", obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== 16'(ed[i]) || obs_ch[i] !== 2'd0 || obs_last[i] !== (i == 3)) begin
        n_bad++; $display("FAIL single_result[%0d]: got data=%0d ch=%0d last=%0b expected data=%0d ch=0 last=%0b",
                          i, $signed(obs_data[i]), obs_ch[i], obs_last[i], ed[i], (i == 3));
      end
    end
  endtask

  task automatic test_multi_channel;
    int ed [4] = '{25, 40, -1, -3};
    logic [1:0] ec [4] = '{2'd1, 2'd1, 2'd3, 2'd3};
    pix[0] = '{99, 99, 99, 99, 99, 99, 99, 99, 0, 0, 0, 0, 0, 0, 0, 0};
    pix[1] = '{10, 20, 30, 40, 15, 25, -5, 35, 0, 0, 0, 0, 0, 0, 0, 0};
    pix[2] = '{77, 77, 77, 77, 77, 77, 77, 77, 0, 0, 0, 0, 0, 0, 0, 0};
    pix[3] = '{-1, -2, -3, -4, -5, -6, -7, -8, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int c = 0; c < NCH; c++) npix[c] = 8;
    run_job(4, 2, 4'b1010, 0, 0, -1, 0);
    n_cmp++;
    if (obs_data.size() !== 4) begin
      n_bad++; $display("FAIL multi_count: got %0d expected 4", obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== 16'(ed[i]) || obs_ch[i] !== ec[i] || obs_last[i] !== (i % 2 == 1)) begin
        n_bad++; $display("FAIL multi_result[%0d]: got data=%0d ch=%0d last=%0b expected data=%0d ch=%0d last=%0b",
                          i, $signed(obs_data[i]), obs_ch[i], obs_last[i], ed[i], ec[i], (i % 2 == 1));
      end
    end
    n_cmp++;
    if ((ptr[0] !== 0) || (ptr[2] !== 0)) begin
      n_bad++; $display("FAIL unmasked_consumed: got ch0=%0d ch2=%0d expected 0/0", ptr[0], ptr[2]);
    end
  endtask

  task automatic test_backpressure;
    int ed [4] = '{7, 8, 0, -2};
    pix[2] = '{7, -1, 2, 2, -9, 3, 8, -6, 0, 0, -2, -3, -1, 0, -4, -2};
    npix[0] = 0; npix[1] = 0; npix[2] = 16; npix[3] = 0;
    run_job(4, 4, 4'b0100, 1, 1, -1, 0);
    n_cmp++;
    if (obs_data.size() !== 4) begin
      n_bad++; $display("FAIL bp_count: got %0d expected 4", obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== 16'(ed[i]) || obs_ch[i] !== 2'd2 || obs_last[i] !== (i == 3)) begin
        n_bad++; $display("FAIL bp_result[%0d]: got data=%0d ch=%0d last=%0b expected data=%0d ch=2 last=%0b",
                          i, $signed(obs_data[i]), obs_ch[i], obs_last[i], ed[i], (i == 3));
      end
    end
  endtask

  task automatic test_reset_midjob;
    int ed [4] = '{5, 4, -3, 10};
    load_ch0_grid();
    run_job(4, 4, 4'b0001, 0, 0, -1, 7);
    #2;
    rst_async_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, done_o, err_o, pool_valid_o, in_ready_o, res_ready_o, out_valid_o, out_last_o} !== 11'd0) begin
      n_bad++; $display("FAIL midjob_reset_outputs: got %b expected all zero",
                        {busy_o, done_o, err_o, pool_valid_o, in_ready_o, res_ready_o, out_valid_o, out_last_o});
    end
    n_cmp++;
    if (pool_fm_w_o !== 32'd0) begin
      n_bad++; $display("FAIL midjob_reset_cfg: got %0d expected 0", pool_fm_w_o);
    end
    n_cmp++;
    if (done_cnt !== 0) begin
      n_bad++; $display("FAIL midjob_no_done: got %0d expected 0", done_cnt);
    end
    in_valid_i = '0; res_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_async_n_i = 1'b1;
    run_job(4, 4, 4'b0001, 0, 0, -1, 0);
    n_cmp++;
    if (obs_data.size() !== 4) begin
      n_bad++; $display("FAIL restart_count: got %0d expected 4", obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== 16'(ed[i]) || obs_last[i] !== (i == 3)) begin
        n_bad++; $display("FAIL restart_result[%0d]: got data=%0d last=%0b expected data=%0d last=%0b",
                          i, $signed(obs_data[i]), obs_last[i], ed[i], (i == 3));
      end
    end
  endtask

  task automatic test_start_while_busy;
    int ed [4] = '{5, 4, -3, 10};
    load_ch0_grid();
    run_job(4, 4, 4'b0001, 0, 0, 5, 0);
    n_cmp++;
    if (obs_data.size() !== 4) begin
      n_bad++; $display("FAIL busy_start_count: got %0d expected 4", obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== 16'(ed[i]) || obs_ch[i] !== 2'd0) begin
        n_bad++; $display("FAIL busy_start_result[%0d]: got data=%0d ch=%0d expected data=%0d ch=0",
                          i, $signed(obs_data[i]), obs_ch[i], ed[i]);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL busy_start_idle: got %0b expected 0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_config_error();
    test_single_channel();
    test_multi_channel();
    test_backpressure();
    test_reset_midjob();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pool_channel_scheduler.md
POOL_CHANNEL_SCHEDULER -- requirements
Module: pool_channel_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting channel streams.
REQ-002 Parameter WIDTH, default ACC_WIDTH, pixel width.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 rst_async_n_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  job start request, sampled only in IDLE.
REQ-006 fm_w_i / fm_h_i  input  16 each  feature-map width/height, latched at start.
REQ-007 ch_mask_i  input  NUM_CH  channels to process this job, latched at start.
REQ-008 busy_o, done_o, err_o  output  1 each  job active; done pulse; config-error pulse.
REQ-009 in_valid_i / in_ready_o  input / output  NUM_CH each  per-channel input handshake.
REQ-010 in_data_i  input  NUM_CH x WIDTH  per-channel pixel data.
REQ-011 pool_valid_o / pool_ready_i / pool_data_o  output / input / output  1 / 1 / WIDTH  stream to pooling core.
REQ-012 pool_fm_w_o  output  32  latched width, zero-extended, to pooling core.
REQ-013 res_valid_i / res_ready_o / res_data_i  input / output / input  1 / 1 / WIDTH  pooled result from core.
REQ-014 out_valid_o / out_ready_i / out_data_o  output / input / output  1 / 1 / WIDTH  tagged result stream.
REQ-015 out_ch_o / out_last_o  output  clog2(NUM_CH) / 1  channel tag; last pooled pixel of that channel.

Function
REQ-016 FSM states IDLE, STREAM, DRAIN; the shared pooling core SHALL serve one whole channel feature map at a time, never interleaved.
REQ-017 IDLE + start_i with fm_w_i or fm_h_i zero or odd, or ch_mask_i==0: err_o pulses 1 cycle next cycle, stay IDLE, no config latched.
REQ-018 IDLE + valid start_i: latch W, H, mask; cur_ch = lowest set mask bit; go STREAM; busy_o=1 from next cycle until return to IDLE.
REQ-019 STREAM: pool_valid_o = in_valid_i[cur_ch], pool_data_o = in_data_i[cur_ch], in_ready_o[cur_ch] = pool_ready_i, all other in_ready_o = 0 (combinational mux, zero latency).
REQ-020 Input counter increments per accepted pixel (pool_valid_o && pool_ready_i); after W*H-th accepted pixel go DRAIN; in DRAIN and IDLE pool_valid_o=0, all in_ready_o=0.
REQ-021 Result path: out_valid_o=res_valid_i, out_data_o=res_data_i, res_ready_o=out_ready_i, out_ch_o=cur_ch, combinational, in STREAM and DRAIN; forced low in IDLE.
REQ-022 Output counter increments per accepted result; out_last_o=1 when counter == (W/2)*(H/2)-1 and out_valid_o.
REQ-023 Channel complete when (W/2)*(H/2)-th result accepted (may occur in STREAM same cycle as or before last input; switch only from DRAIN once both counts complete).
REQ-024 On completion: both counters clear; next cur_ch = next higher set mask bit -> STREAM; if none, done_o pulses 1 cycle, go IDLE.
REQ-025 Counters 32 bits; W*H computed once at latch into a 32-bit register.
REQ-026 start_i while busy_o ignored; config inputs ignored outside IDLE.
REQ-027 Even W and H guarantee core row parity returns to even-row at every channel boundary; no core reset between channels.

Reset
REQ-028 Reset: FSM IDLE, counters 0, cur_ch 0, latched config 0, busy_o/done_o/err_o 0; all valid/ready outputs 0.
REQ-029 Reset mid-job abandons job, no done_o; pooling core shares rst_async_n_i so both restart consistent.

Structure
REQ-030 ACC_WIDTH, MAX_LINE_W and the FSM state enum live in the shared definitions package.
REQ-031 One sub-module natural: pool_ch_rr_pick (next-set-bit-above-index finder over NUM_CH mask).

Verification
REQ-032 W=4,H=4,mask=4'b0001, always-ready: 16 inputs ch0 -> 4 outputs tag 0, out_last_o on 4th, done_o once, busy_o low after.
REQ-033 W=4,H=2,mask=4'b1010: ch1 then ch3 served, 2 outputs each with tags 1 then 3; ch0/ch2 in_ready_o always 0.
REQ-034 start_i with W=5,H=4 -> err_o one pulse, busy_o stays 0; start with mask=0 -> err_o.
REQ-035 W=4,H=4, out_ready_i toggling 50% and random in_valid_i: outputs equal expected 2x2 signed max, no loss or duplication.
REQ-036 Assert reset after 7 inputs of ch0: all outputs 0 at reset; fresh start W=4,H=4 produces correct 4 results.
REQ-037 start_i pulsed during busy: ignored, single done_o for original job.
